// File: rtl/cdc_bus_tx.sv
// Two-phase (toggle) request/acknowledge bus transmitter with a STAGES-deep rx_ack synchronizer.
// Optional one-word skid register enabled by defining CDC_BUS_TX_SKID_EN.
module cdc_bus_tx #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             rx_ack,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [STAGES-1:0] sync;
    logic              ack_sync;
    logic              accept;
    logic              done;
    logic              tx_req_nxt;
    logic [WIDTH-1:0]  tx_data_nxt;
    logic              in_ready_nxt;
    logic              busy_nxt;
`ifdef CDC_BUS_TX_SKID_EN
    logic [WIDTH-1:0]  skid;
    logic [WIDTH-1:0]  skid_nxt;
    logic              skid_full;
    logic              skid_full_nxt;
`endif

    // rx_ack synchronizer; only the last stage feeds logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], rx_ack};
        end
    end

    assign ack_sync = sync[STAGES-1];
    assign accept   = in_valid && in_ready;
    assign done     = (state == WAIT) && (ack_sync == tx_req);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_req   <= 1'b0;
            tx_data  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
`ifdef CDC_BUS_TX_SKID_EN
            skid      <= '0;
            skid_full <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            tx_req   <= tx_req_nxt;
            tx_data  <= tx_data_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
`ifdef CDC_BUS_TX_SKID_EN
            skid      <= skid_nxt;
            skid_full <= skid_full_nxt;
`endif
        end
    end

    // Next-state: a launch toggles tx_req and loads tx_data in the same edge
    always_comb begin
        state_nxt   = state;
        tx_req_nxt  = tx_req;
        tx_data_nxt = tx_data;
`ifdef CDC_BUS_TX_SKID_EN
        skid_nxt      = skid;
        skid_full_nxt = skid_full;
`endif
        if (state == IDLE) begin
`ifdef CDC_BUS_TX_SKID_EN
            // A word buffered at a plain completion edge is launched from IDLE
            if (skid_full) begin
                tx_data_nxt   = skid;
                tx_req_nxt    = !tx_req;
                state_nxt     = WAIT;
                skid_full_nxt = 1'b0;
            end else
`endif
            if (accept) begin
                tx_data_nxt = in_data;
                tx_req_nxt  = !tx_req;
                state_nxt   = WAIT;
            end
        end else begin
            if (done) begin
`ifdef CDC_BUS_TX_SKID_EN
                if (skid_full) begin
                    tx_data_nxt   = skid;
                    tx_req_nxt    = !tx_req;
                    skid_full_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
`ifdef CDC_BUS_TX_SKID_EN
            if (accept) begin
                skid_nxt      = in_data;
                skid_full_nxt = 1'b1;
            end
`endif
        end

`ifdef CDC_BUS_TX_SKID_EN
        in_ready_nxt = !skid_full_nxt;
        busy_nxt     = (state_nxt == WAIT) || skid_full_nxt;
`else
        in_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt == WAIT);
`endif
    end

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Self-checking bench for cdc_bus_tx: vector table, hand sequences, and randomized traffic
// against a loopback remote model and an in-order word scoreboard.
`timescale 1ns/1ps
module tb_cdc_bus_tx;

    localparam int unsigned STAGES = 2;
    localparam int unsigned WIDTH  = 8;
`ifdef CDC_BUS_TX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             rx_ack_tb = 1'b0;
    logic             remote_en = 1'b0;
    logic             rx_ack_remote = 1'b0;
    logic             seen_req  = 1'b0;
    int               remote_cnt   = 0;
    int               remote_delay = 3;
    logic             rx_ack;
    logic             in_ready;
    logic             tx_req;
    logic [WIDTH-1:0] tx_data;
    logic             busy;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] rx_q[$];
    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             ack;
        logic             rdy;
        logic             req;
        logic [WIDTH-1:0] data;
        logic             bsy;
    } vec_t;

    vec_t tbl[14];

    assign rx_ack = remote_en ? rx_ack_remote : rx_ack_tb;

    cdc_bus_tx #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .rx_ack   (rx_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Remote end: capture each launched word, echo the toggle back after remote_delay cycles
    always @(negedge clk) begin
        if (!remote_en) begin
            seen_req      <= tx_req;
            rx_ack_remote <= rx_ack_tb;
            remote_cnt    <= 0;
        end else begin
            if (remote_cnt == 1) rx_ack_remote <= seen_req;
            if (remote_cnt > 0) remote_cnt <= remote_cnt - 1;
            if (tx_req != seen_req) begin
                seen_req <= tx_req;
                rx_q.push_back(tx_data);
                remote_cnt <= remote_delay;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int toggles;
        int t_last;
        logic prev;
        bit drained;

        //            v   d      ack  rdy  req  data   bsy
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[2]  = '{1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[5]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};

        // Reset state
        #12;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_req",   32'(tx_req),   32'd0);
        check("rst_data",  32'(tx_data),  32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: single transfer, stale-ack wait, idle ack glitch
        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            rx_ack_tb = tbl[i].ack;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 32'(in_ready), SKID ? 32'd1 : 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_req", i),   32'(tx_req),   32'(tbl[i].req));
            check($sformatf("tbl%0d_data", i),  32'(tx_data),  32'(tbl[i].data));
            check($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].bsy));
        end

        // Data stability while ack is withheld
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        rx_ack_tb = 1'b0;
        @(negedge clk);
        check("stab_launch_req",  32'(tx_req),  32'd1);
        check("stab_launch_data", 32'(tx_data), 32'hA5);
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i);
            @(negedge clk);
            check("stab_data", 32'(tx_data), 32'hA5);
            check("stab_req",  32'(tx_req),  32'd1);
            check("stab_busy", 32'(busy),    32'd1);
        end

        // Reset mid-transfer clears outputs without a clock edge
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rx_ack_tb = 1'b0;
        #1;
        check("midrst_req",   32'(tx_req),   32'd0);
        check("midrst_data",  32'(tx_data),  32'd0);
        check("midrst_busy",  32'(busy),     32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", 32'(in_ready), 32'd1);
        check("postrst_busy",  32'(busy),     32'd0);

`ifdef CDC_BUS_TX_SKID_EN
        // Skid: second word buffered during WAIT, launched at the completion edge
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        check("skid_l1_req",  32'(tx_req),  32'd1);
        check("skid_l1_data", 32'(tx_data), 32'h11);
        in_data = 8'h5A;
        @(negedge clk);
        check("skid_full_ready", 32'(in_ready), 32'd0);
        check("skid_full_data",  32'(tx_data),  32'h11);
        check("skid_full_busy",  32'(busy),     32'd1);
        in_valid  = 1'b0;
        rx_ack_tb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("skid_pre_data", 32'(tx_data), 32'h11);
        @(negedge clk);
        check("skid_cmp_data",  32'(tx_data),  32'h5A);
        check("skid_cmp_req",   32'(tx_req),   32'd0);
        check("skid_cmp_busy",  32'(busy),     32'd1);
        check("skid_cmp_ready", 32'(in_ready), 32'd1);
        rx_ack_tb = 1'b0;
        repeat (4) @(negedge clk);
        check("skid_end_busy", 32'(busy), 32'd0);
`endif

        // Back-to-back with loopback ack delay of 3 cycles
        remote_delay = 3;
        remote_en    = 1'b1;
        rx_q.delete();
        idx     = 0;
        toggles = 0;
        t_last  = 0;
        prev    = tx_req;
        for (int c = 0; c < 60; c++) begin
            if (tx_req != prev) begin
                prev = tx_req;
                if (toggles > 0)
                    check("b2b_gap", 32'(c - t_last), 32'(STAGES + 3 + (SKID ? 1 : 2)));
                t_last = c;
                toggles++;
            end
            in_valid = (idx < 3);
            in_data  = 8'(idx + 1);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_toggles", 32'(toggles), 32'd3);
        check("b2b_count", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check($sformatf("b2b_word%0d", i), 32'(rx_q[i]), 32'(i + 1));
        check("b2b_idle", 32'(busy), 32'd0);

        // Randomized traffic against the in-order scoreboard
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            remote_delay = int'($urandom_range(1, 4));
            in_valid     = ($urandom_range(0, 2) != 0);
            in_data      = 8'($urandom);
            if (in_valid && in_ready) exp_q.push_back(in_data);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drained  = 1'b0;
        for (int c = 0; c < 200 && !drained; c++) begin
            @(negedge clk);
            if (!busy && remote_cnt == 0) drained = 1'b1;
        end
        check("rnd_drain", 32'(drained), 32'd1);
        check("rnd_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rnd_word%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        check("rnd_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdc_bus_tx.md
CDC_BUS_TX -- requirements
Module: cdc_bus_tx

Interface
REQ-001 SHALL have parameter STAGES, default 2: number of flops in the internal rx_ack synchronizer chain (legal value >= 2).
REQ-002 SHALL have parameter WIDTH, default 8: payload width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the local producer offers in_data.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: the payload.
REQ-008 SHALL have port tx_req, output, 1 bit: two-phase request toggle sent to the remote domain.
REQ-009 SHALL have port tx_data, output, WIDTH bits: the launched payload, registered.
REQ-010 SHALL have port rx_ack, input, 1 bit: two-phase acknowledge toggle from the remote domain, asynchronous to clk.
REQ-011 SHALL have port busy, output, 1 bit: a transfer is outstanding or buffered.

Function
REQ-012 SHALL pass rx_ack through a STAGES-deep flop chain clocked by clk; only the last stage, ack_sync, SHALL be used by any logic.
REQ-013 SHALL implement two states: IDLE (no transfer outstanding) and WAIT (tx_req toggled, ack pending).
REQ-014 SHALL, in IDLE with in_valid && in_ready at edge N, load tx_data <= in_data, invert tx_req, and enter WAIT, all at edge N.
REQ-015 SHALL change tx_data only at the same edge at which tx_req toggles; tx_data SHALL hold stable for the whole of WAIT.
REQ-016 SHALL treat a transfer as complete when, in WAIT, ack_sync == tx_req; at that edge the state SHALL go to IDLE unless REQ-019 applies.
REQ-017 SHALL ignore the value of ack_sync while in IDLE.
REQ-018 SHALL, without the skid buffer, drive in_ready = (state == IDLE); a completion cycle SHALL NOT also accept, so back-to-back transfers take one IDLE cycle between them.
REQ-019 SHALL, with the skid buffer full at a completion edge, launch the buffered word at that edge (tx_data <= skid, tx_req inverted), stay in WAIT, and mark the buffer empty.
REQ-020 SHALL drive busy = (state == WAIT) || skid_full; skid_full SHALL be 0 when the buffer is absent.
REQ-021 SHALL ignore in_data when in_valid && in_ready is false; no word SHALL be dropped or duplicated.
REQ-022 SHALL require minimum round-trip latency from the tx_req toggle to IDLE of STAGES cycles plus the remote ack delay.

Reset
REQ-023 SHALL, while rst_n = 0, asynchronously force: tx_req = 0, tx_data = 0, all synchronizer flops = 0, state = IDLE, skid buffer empty, busy = 0, and in_ready = 0.
REQ-024 SHALL drive in_ready per REQ-018 or REQ-026 from the first clk edge after rst_n deasserts.
REQ-025 SHALL abandon any transfer in progress on reset mid-transfer; correct operation after this requires the remote end to be reset at the same time, so that rx_ack = 0.

Configuration
REQ-026 SHALL, when macro CDC_BUS_TX_SKID_EN is defined, include a one-word skid register: in_ready = !skid_full; accepts in IDLE follow REQ-014; accepts in WAIT write the skid register and set skid_full.
REQ-027 SHALL, when CDC_BUS_TX_SKID_EN is undefined, omit the skid register entirely and behave per REQ-018.

Verification
REQ-028 SHALL cover single transfer: STAGES=2, in_data=8'hA5 accepted at edge N -> tx_req 0->1 and tx_data=8'hA5 at N; rx_ack raised after N -> in_ready=1 two edges after its first sampling.
REQ-029 SHALL cover data stability: hold rx_ack=0 for 20 cycles while in_valid=1 with changing in_data -> tx_data stays 8'hA5, tx_req stays 1, busy=1 throughout.
REQ-030 SHALL cover back-to-back without skid: words 8'h01, 8'h02, 8'h03 with a loopback ack delay of 3 cycles -> tx_req toggles 3 times, remote sees 01,02,03 in order, one IDLE cycle between transfers.
REQ-031 SHALL cover skid enabled: second word 8'h5A offered during WAIT -> accepted at once; at the completion edge tx_data=8'h5A, tx_req toggles, state stays WAIT, in_ready returns to 1.
REQ-032 SHALL cover reset mid-transfer: assert rst_n=0 during WAIT with tx_req=1 -> tx_req=0, tx_data=0, busy=0 immediately, without a clk edge.
REQ-033 SHALL cover an ack glitch in IDLE: toggle rx_ack while idle -> no state change, in_ready stays 1.
